// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: ALU opcode encodings,
// the ALU's result for unassigned opcodes, and the sequencer FSM states.
package alu_seq_pkg;

  localparam logic [3:0] ALU_OP_ZERO    = 4'd0;
  localparam logic [3:0] ALU_OP_A       = 4'd1;
  localparam logic [3:0] ALU_OP_B       = 4'd2;
  localparam logic [3:0] ALU_OP_NEG_A   = 4'd3;
  localparam logic [3:0] ALU_OP_NEG_B   = 4'd4;
  localparam logic [3:0] ALU_OP_ROR_A   = 4'd5;
  localparam logic [3:0] ALU_OP_ROR_B   = 4'd6;
  localparam logic [3:0] ALU_OP_LT      = 4'd7;
  localparam logic [3:0] ALU_OP_BITWISE = 4'd8;
  localparam logic [3:0] ALU_OP_NOT_A   = 4'd9;
  localparam logic [3:0] ALU_OP_NOT_B   = 4'd10;
  localparam logic [3:0] ALU_OP_SUB     = 4'd11;
  localparam logic [3:0] ALU_OP_ADD     = 4'd12;
  localparam logic [3:0] ALU_OP_ONES    = 4'd15;

  localparam logic [7:0] ALU_DEFAULT_RESULT = 8'h81;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Drives (op, a, b) commands into the ALU, waits SETTLE_CYCLES, returns the result.
// Optional ALU_SEQ_SWEEP_EN: cmd_sweep/rsp_last ports and a 16-opcode sweep mode.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned W             = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [3:0]   alu_sel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_x,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [3:0]   rsp_op,
  output logic         busy
`ifdef ALU_SEQ_SWEEP_EN
  ,
  input  logic         cmd_sweep,
  output logic         rsp_last
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu_cmd_sequencer: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_t state, state_nxt;
  logic [3:0] cnt;
  logic       accept, sample, rsp_hs;
  logic       sweep_more;
  logic [3:0] first_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      ST_IDLE: if (cmd_valid) begin
        accept    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (cnt == '0) begin
        sample    = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: if (rsp_ready) begin
        rsp_hs    = 1'b1;
        state_nxt = sweep_more ? ST_WAIT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
    end else begin
      if (accept) begin
        alu_sel <= first_op;
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
        cnt     <= CNT_LOAD;
      end
      if (state == ST_WAIT && cnt != '0) cnt <= cnt - 4'd1;
      if (sample) begin
        rsp_valid <= 1'b1;
        rsp_data  <= alu_x;
        rsp_op    <= alu_sel;
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        // A sweep steps to the next opcode and settles again on the same operands.
        if (sweep_more) begin
          alu_sel <= alu_sel + 4'd1;
          cnt     <= CNT_LOAD;
        end
      end
    end
  end

`ifdef ALU_SEQ_SWEEP_EN
  logic sweep_act;

  assign sweep_more = sweep_act && (alu_sel != ALU_OP_ONES);
  assign first_op   = cmd_sweep ? ALU_OP_ZERO : cmd_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_act <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      if (accept) sweep_act <= cmd_sweep;
      if (sample) rsp_last <= sweep_act && (alu_sel == ALU_OP_ONES);
      if (rsp_hs) begin
        rsp_last <= 1'b0;
        if (!sweep_more) sweep_act <= 1'b0;
      end
    end
  end
`else
  assign sweep_more = 1'b0;
  assign first_op   = cmd_op;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU as responder;
// two instances cover SETTLE_CYCLES=1 and 3, sweep checks under ALU_SEQ_SWEEP_EN.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  int         n_chk = 0;
  int         n_pass = 0;

  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [3:0] cmd_op, alu_sel, rsp_op;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_x, rsp_data;

  logic       cmd_valid_3, cmd_ready_3, rsp_valid_3, rsp_ready_3, busy_3;
  logic [3:0] cmd_op_3, alu_sel_3, rsp_op_3;
  logic [7:0] cmd_a_3, cmd_b_3, alu_a_3, alu_b_3, alu_x_3, rsp_data_3;

`ifdef ALU_SEQ_SWEEP_EN
  logic cmd_sweep, rsp_last, cmd_sweep_3, rsp_last_3;
`endif

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    case (op)
      ALU_OP_ZERO:    return 8'h00;
      ALU_OP_A:       return a;
      ALU_OP_B:       return b;
      ALU_OP_NEG_A:   return 8'h00 - a;
      ALU_OP_NEG_B:   return 8'h00 - b;
      ALU_OP_ROR_A:   return {a[3:0], a[7:4]};
      ALU_OP_ROR_B:   return {b[3:0], b[7:4]};
      ALU_OP_LT:      return (a < b) ? 8'h01 : 8'h00;
      ALU_OP_BITWISE: return a & b;
      ALU_OP_NOT_A:   return ~a;
      ALU_OP_NOT_B:   return ~b;
      ALU_OP_SUB:     return a - b;
      ALU_OP_ADD:     return a + b;
      ALU_OP_ONES:    return 8'hFF;
      default:        return ALU_DEFAULT_RESULT;
    endcase
  endfunction

  assign alu_x   = alu_model(alu_sel, alu_a, alu_b);
  assign alu_x_3 = alu_model(alu_sel_3, alu_a_3, alu_b_3);

  alu_cmd_sequencer #(.W(8), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_sel(alu_sel), .alu_a(alu_a),
    .alu_b(alu_b), .alu_x(alu_x), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .busy(busy)
`ifdef ALU_SEQ_SWEEP_EN
    , .cmd_sweep(cmd_sweep), .rsp_last(rsp_last)
`endif
  );

  alu_cmd_sequencer #(.W(8), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
    .cmd_op(cmd_op_3), .cmd_a(cmd_a_3), .cmd_b(cmd_b_3), .alu_sel(alu_sel_3),
    .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_x(alu_x_3), .rsp_valid(rsp_valid_3),
    .rsp_ready(rsp_ready_3), .rsp_data(rsp_data_3), .rsp_op(rsp_op_3), .busy(busy_3)
`ifdef ALU_SEQ_SWEEP_EN
    , .cmd_sweep(cmd_sweep_3), .rsp_last(rsp_last_3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command to the SETTLE_CYCLES=1 instance; returns after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp);
    issue(op, a, b);
    check({tag, "_busy"}, busy, 1);
    wait_rsp(tag, 1);
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_op"}, rsp_op, op);
    tick();
    check({tag, "_done"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    logic [7:0] sw_exp [16];
    int n;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    cmd_valid_3 = 1'b0; cmd_op_3 = '0; cmd_a_3 = '0; cmd_b_3 = '0; rsp_ready_3 = 1'b1;
`ifdef ALU_SEQ_SWEEP_EN
    cmd_sweep = 1'b0; cmd_sweep_3 = 1'b0;
`endif
    #12;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_op", rsp_op, 0);
    check("rst_alu", {alu_sel, alu_a, alu_b}, 0);
    check("rst_ready_busy", {cmd_ready, busy}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_cmd("add", ALU_OP_ADD, 8'h05, 8'h03, 8'h08);
    run_cmd("op13", 4'd13, 8'h12, 8'h34, 8'h81);
    run_cmd("op15", ALU_OP_ONES, 8'h12, 8'h34, 8'hFF);
    check("hold_alu", {alu_sel, alu_a, alu_b}, {4'hF, 8'h12, 8'h34});
    run_cmd("op0", ALU_OP_ZERO, 8'h12, 8'h34, 8'h00);

    // Backpressure: response must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    issue(ALU_OP_ROR_A, 8'h0F, 8'h00);
    wait_rsp("ror", 1);
    for (int i = 0; i < 5; i++) begin
      check("ror_hold", {rsp_valid, cmd_ready, rsp_data, rsp_op},
            {1'b1, 1'b0, 8'hF0, ALU_OP_ROR_A});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("ror_release", {rsp_valid, cmd_ready}, 2'b01);

    // Longer settle on the second instance.
    cmd_valid_3 = 1'b1; cmd_op_3 = ALU_OP_SUB; cmd_a_3 = 8'h09; cmd_b_3 = 8'h04;
    tick();
    cmd_valid_3 = 1'b0;
    n = 0;
    while (!rsp_valid_3 && n < 20) begin
      tick();
      n++;
    end
    check("sub3_lat", n, 3);
    check("sub3_data", {rsp_op_3, rsp_data_3}, {ALU_OP_SUB, 8'h05});
    tick();
    check("sub3_done", {rsp_valid_3, cmd_ready_3}, 2'b01);

    // Asynchronous abort mid-flight.
    issue(ALU_OP_ADD, 8'h40, 8'h01);
    check("abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs", {rsp_valid, busy, cmd_ready, alu_sel, alu_a, alu_b, rsp_data},
          {1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("abort_no_rsp", rsp_valid, 0);
    run_cmd("post_rst", ALU_OP_ADD, 8'h10, 8'h20, 8'h30);

`ifdef ALU_SEQ_SWEEP_EN
    sw_exp = '{8'h00, 8'h0F, 8'hF0, 8'hF1, 8'h10, 8'hF0, 8'h0F, 8'h01,
               8'h00, 8'hF0, 8'h0F, 8'h1F, 8'hFF, 8'h81, 8'h81, 8'hFF};
    cmd_sweep = 1'b1;
    issue(ALU_OP_ADD, 8'h0F, 8'hF0);
    cmd_sweep = 1'b0;
    for (int k = 0; k < 16; k++) begin
      wait_rsp("sweep", 1);
      check("sweep_op", rsp_op, k);
      check("sweep_data", rsp_data, sw_exp[k]);
      check("sweep_last", rsp_last, (k == 15));
      check("sweep_ready", cmd_ready, 0);
      tick();
    end
    check("sweep_end", {rsp_valid, cmd_ready, rsp_last}, 3'b010);
`else
    sw_exp = '{default: 8'h00};
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
